// File: rtl/image_stream_fetch.sv
// Training-image fetch sequencer: walks the image RAM once per epoch and
// presents each registered word on a valid/ready stream with index/epoch tags.
module image_stream_fetch #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 785,
   parameter int unsigned NUM_IMAGES = 16384
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            epochs,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-2:0] pix_data,
   output logic                  pix_label,
   output logic [ADDR_WIDTH-1:0] img_idx,
   output logic                  img_last,
   output logic [7:0]            epoch_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_HOLD,
      S_DONE
   } state_t;

   // Wrap point is an explicit compare so NUM_IMAGES == 2**ADDR_WIDTH also works.
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_IMAGES - 1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [7:0]              epoch_q, epoch_d;
   logic [7:0]              epoch_total_q, epoch_total_d;
   logic [DATA_WIDTH-1:0]   word_q, word_d;
   logic [ADDR_WIDTH-1:0]   img_idx_q, img_idx_d;
   logic                    img_last_q, img_last_d;
   logic [7:0]              epoch_idx_q, epoch_idx_d;
   logic                    done_q, done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         epoch_q       <= '0;
         epoch_total_q <= '0;
         word_q        <= '0;
         img_idx_q     <= '0;
         img_last_q    <= 1'b0;
         epoch_idx_q   <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         epoch_q       <= epoch_d;
         epoch_total_q <= epoch_total_d;
         word_q        <= word_d;
         img_idx_q     <= img_idx_d;
         img_last_q    <= img_last_d;
         epoch_idx_q   <= epoch_idx_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      epoch_d       = epoch_q;
      epoch_total_d = epoch_total_q;
      word_d        = word_q;
      img_idx_d     = img_idx_q;
      img_last_d    = img_last_q;
      epoch_idx_d   = epoch_idx_q;
      done_d        = 1'b0;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               epoch_total_d = (epochs == 8'd0) ? 8'd1 : epochs;
               idx_d         = '0;
               epoch_d       = '0;
               state_d       = S_RD;
            end
         end
         S_RD: begin
            state_d = S_CAP;
         end
         S_CAP: begin
            word_d      = ram_dout;
            img_idx_d   = idx_q;
            img_last_d  = (idx_q == LAST_IDX);
            epoch_idx_d = epoch_q;
            state_d     = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  if (epoch_q == epoch_total_q - 8'd1) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     idx_d   = '0;
                     epoch_d = epoch_q + 8'd1;
                     state_d = S_RD;
                  end
               end else begin
                  idx_d   = idx_q + ADDR_WIDTH'(1);
                  state_d = S_RD;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy      = (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_HOLD);
      done      = done_q;
      ram_en    = (state_q == S_RD);
      ram_we    = 1'b0;
      ram_addr  = idx_q;
      out_valid = (state_q == S_HOLD);
      pix_data  = word_q[DATA_WIDTH-2:0];
      pix_label = word_q[DATA_WIDTH-1];
      img_idx   = img_idx_q;
      img_last  = img_last_q;
      epoch_idx = epoch_idx_q;
   end

endmodule
